// File: rtl/counter_pkg.sv
// Shared constants and types for the up/down counter core.
package counter_pkg;

    localparam int unsigned COUNT_WIDTH_DEF = 8;
    localparam logic [COUNT_WIDTH_DEF-1:0] COUNT_MAX_DEF = {COUNT_WIDTH_DEF{1'b1}};

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_SET  = 3'd1,
        SEL_LOAD = 3'd2,
        SEL_UP   = 3'd3,
        SEL_DOWN = 3'd4
    } sel_e;

endpackage

// File: rtl/count_next_sel.sv
// Combinational next-count / flag selection for up_down_count_core.
// COUNT_SAT_EN defined: counting clamps at the bounds instead of wrapping.
module count_next_sel
    import counter_pkg::*;
#(
    parameter int CountWidth = COUNT_WIDTH_DEF
) (
    input  logic                  i_set,
    input  logic                  i_load,
    input  logic [CountWidth-1:0] i_preld_val,
    input  logic                  i_enable,
    input  logic                  i_up,
    input  logic [CountWidth-1:0] i_count,
    output logic [CountWidth-1:0] o_next_count,
    output logic                  o_next_zero,
    output logic                  o_next_carry,
    output logic                  o_next_ack
);

    localparam logic [CountWidth-1:0] CountMax  = {CountWidth{1'b1}};
    localparam logic [CountWidth-1:0] CountZero = {CountWidth{1'b0}};
    localparam logic [CountWidth-1:0] CountOne  = {{(CountWidth-1){1'b0}}, 1'b1};

    sel_e                  w_sel;
    logic [CountWidth-1:0] w_next_count;
    logic                  w_next_carry;
    logic                  w_next_ack;

    // Resolve control priority: set > load > count > hold.
    always_comb begin
        w_sel = SEL_HOLD;
        if (i_set) begin
            w_sel = SEL_SET;
        end else if (i_load) begin
            w_sel = SEL_LOAD;
        end else if (i_enable) begin
            if (i_up == CNT_UP) begin
                w_sel = SEL_UP;
            end else begin
                w_sel = SEL_DOWN;
            end
        end else begin
            w_sel = SEL_HOLD;
        end
    end

    // Compute the next count and the event flags for the selected action.
    always_comb begin
        w_next_count = i_count;
        w_next_carry = 1'b0;
        w_next_ack   = 1'b0;
        case (w_sel)
            SEL_SET: begin
                w_next_count = CountMax;
            end
            SEL_LOAD: begin
                w_next_count = i_preld_val;
                w_next_ack   = 1'b1;
            end
            SEL_UP: begin
                if (i_count == CountMax) begin
                    w_next_carry = 1'b1;
`ifdef COUNT_SAT_EN
                    w_next_count = CountMax;
`else
                    w_next_count = CountZero;
`endif
                end else begin
                    w_next_count = i_count + CountOne;
                end
            end
            SEL_DOWN: begin
                if (i_count == CountZero) begin
                    w_next_carry = 1'b1;
`ifdef COUNT_SAT_EN
                    w_next_count = CountZero;
`else
                    w_next_count = CountMax;
`endif
                end else begin
                    w_next_count = i_count - CountOne;
                end
            end
            SEL_HOLD: begin
                w_next_count = i_count;
            end
            default: begin
                w_next_count = i_count;
            end
        endcase
    end

    assign o_next_count = w_next_count;
    assign o_next_zero  = (w_next_count == CountZero);
    assign o_next_carry = w_next_carry;
    assign o_next_ack   = w_next_ack;

endmodule

// File: rtl/up_down_count_core.sv
// Registered up/down counter core with set/load/count priority and event pulses.
// Define COUNT_SAT_EN for saturating rather than wrapping count behaviour.
module up_down_count_core
    import counter_pkg::*;
#(
    parameter int CountWidth = COUNT_WIDTH_DEF
) (
    input  logic                  iClk,
    input  logic                  _iReset,
    input  logic                  iSet,
    input  logic                  iLoad,
    input  logic [CountWidth-1:0] iPreldVal,
    input  logic                  iEnable,
    input  logic                  iUp,
    output logic [CountWidth-1:0] oCountValue,
    output logic                  oZero,
    output logic                  oCarry,
    output logic                  oLoadAck
);

    logic [CountWidth-1:0] r_count;
    logic                  r_zero;
    logic                  r_carry;
    logic                  r_ack;

    logic [CountWidth-1:0] w_next_count;
    logic                  w_next_zero;
    logic                  w_next_carry;
    logic                  w_next_ack;

    count_next_sel #(
        .CountWidth (CountWidth)
    ) u_next_sel (
        .i_set        (iSet),
        .i_load       (iLoad),
        .i_preld_val  (iPreldVal),
        .i_enable     (iEnable),
        .i_up         (iUp),
        .i_count      (r_count),
        .o_next_count (w_next_count),
        .o_next_zero  (w_next_zero),
        .o_next_carry (w_next_carry),
        .o_next_ack   (w_next_ack)
    );

    // Count and flag registers; zero flag registered with the count so they stay aligned.
    always_ff @(posedge iClk or negedge _iReset) begin
        if (!_iReset) begin
            r_count <= {CountWidth{1'b0}};
            r_zero  <= 1'b1;
            r_carry <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_zero  <= w_next_zero;
            r_carry <= w_next_carry;
            r_ack   <= w_next_ack;
        end
    end

    assign oCountValue = r_count;
    assign oZero       = r_zero;
    assign oCarry      = r_carry;
    assign oLoadAck    = r_ack;

endmodule

// File: tb/tb_up_down_count_core.sv
// Self-checking bench for up_down_count_core: arithmetic reference model plus directed vectors.
module tb_up_down_count_core;

`ifdef COUNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int MAXV = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       set_i = 1'b0;
    logic       load_i = 1'b0;
    logic [7:0] preld_i = 8'h00;
    logic       en_i = 1'b0;
    logic       up_i = 1'b0;
    logic [7:0] cnt_o;
    logic       zero_o;
    logic       carry_o;
    logic       ack_o;

    int errors = 0;
    int checks = 0;

    int m_cnt = 0;
    int m_carry = 0;
    int m_ack = 0;

    up_down_count_core #(.CountWidth(8)) dut (
        .iClk        (clk),
        ._iReset     (rst_n),
        .iSet        (set_i),
        .iLoad       (load_i),
        .iPreldVal   (preld_i),
        .iEnable     (en_i),
        .iUp         (up_i),
        .oCountValue (cnt_o),
        .oZero       (zero_o),
        .oCarry      (carry_o),
        .oLoadAck    (ack_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: signed step, then wrap or clamp depending on build.
    always @(posedge clk or negedge rst_n) begin
        int t;
        if (!rst_n) begin
            m_cnt   <= 0;
            m_carry <= 0;
            m_ack   <= 0;
        end else if (set_i) begin
            m_cnt   <= MAXV;
            m_carry <= 0;
            m_ack   <= 0;
        end else if (load_i) begin
            m_cnt   <= int'(preld_i);
            m_carry <= 0;
            m_ack   <= 1;
        end else if (en_i) begin
            t = up_i ? m_cnt + 1 : m_cnt - 1;
            m_ack   <= 0;
            m_carry <= (t > MAXV || t < 0) ? 1 : 0;
            if (SAT) m_cnt <= (t > MAXV) ? MAXV : ((t < 0) ? 0 : t);
            else     m_cnt <= (t + MAXV + 1) % (MAXV + 1);
        end else begin
            m_carry <= 0;
            m_ack   <= 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_count", int'(cnt_o), m_cnt);
        chk("model_zero", int'(zero_o), (m_cnt == 0) ? 1 : 0);
        chk("model_carry", int'(carry_o), m_carry);
        chk("model_ack", int'(ack_o), m_ack);
    end

    task automatic step(input logic s, input logic l, input logic [7:0] v,
                        input logic e, input logic u);
        @(negedge clk);
        set_i = s; load_i = l; preld_i = v; en_i = e; up_i = u;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        set_i = 1'b1; en_i = 1'b1; up_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_count", int'(cnt_o), 0);
            chk("rst_zero", int'(zero_o), 1);
            chk("rst_carry", int'(carry_o), 0);
            chk("rst_ack", int'(ack_o), 0);
        end
        @(negedge clk);
        set_i = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_up", int'(cnt_o), 1);

        step(1'b0, 1'b1, 8'hFD, 1'b0, 1'b0);
        chk("load_fd", int'(cnt_o), 8'hFD);
        chk("load_fd_ack", int'(ack_o), 1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("up_fe", int'(cnt_o), 8'hFE);
        chk("up_fe_ack", int'(ack_o), 0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("up_ff", int'(cnt_o), 8'hFF);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("up_wrap", int'(cnt_o), SAT ? 8'hFF : 8'h00);
        chk("up_wrap_carry", int'(carry_o), 1);
        chk("up_wrap_zero", int'(zero_o), SAT ? 0 : 1);

        step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("down_zero", int'(cnt_o), 8'h00);
        chk("down_zero_flag", int'(zero_o), 1);
        chk("down_zero_carry", int'(carry_o), 0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("down_wrap", int'(cnt_o), SAT ? 8'h00 : 8'hFF);
        chk("down_wrap_carry", int'(carry_o), 1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("down_again_carry", int'(carry_o), SAT ? 1 : 0);

        step(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
        chk("prio_set", int'(cnt_o), 8'hFF);
        chk("prio_set_ack", int'(ack_o), 0);
        step(1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
        chk("prio_load", int'(cnt_o), 8'h55);
        chk("prio_load_ack", int'(ack_o), 1);
        chk("prio_load_carry", int'(carry_o), 0);
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        chk("b2b_load_ack", int'(ack_o), 1);
        chk("b2b_load_zero", int'(zero_o), 1);

        step(1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'h99, 1'b0, logic'(i % 2));
            chk("hold_count", int'(cnt_o), 8'h42);
            chk("hold_carry", int'(carry_o), 0);
            chk("hold_ack", int'(ack_o), 0);
        end

        step(1'b0, 1'b1, 8'h7E, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("pre_async", int'(cnt_o), 8'h80);
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", int'(cnt_o), 0);
        chk("async_zero", int'(zero_o), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_async_up", int'(cnt_o), 1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("post_async_up2", int'(cnt_o), 2);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/up_down_count_core.md
# up_down_count_core

Registered up/down counter core that consumes a selected initial value (reset, set, or preload) and produces the running count fed back to the init-value selection path. It holds the count register, applies the control priority reset > set > load > count > hold every clock, and flags wrap or saturation events and accepted loads. It sits between the control/preload logic and any consumer of the count (comparators, display, terminal-count detection).

## Interface
- CountWidth, 8, width of count and preload value (≥2)
- iClk  input  1  rising-edge clock
- _iReset  input  1  asynchronous, active-low reset
- iSet  input  1  synchronous set: count ← all ones
- iLoad  input  1  synchronous load: count ← iPreldVal
- iPreldVal  input  CountWidth  preload value, sampled only when iLoad wins priority
- iEnable  input  1  count enable
- iUp  input  1  direction: 1 = increment, 0 = decrement
- oCountValue  output  CountWidth  registered count
- oZero  output  1  registered; 1 when oCountValue == 0
- oCarry  output  1  registered one-cycle pulse on wrap (or saturation hit, see Configuration)
- oLoadAck  output  1  registered one-cycle pulse: load taken at previous edge

## Operation
- Reset (_iReset = 0, any time, asynchronous): oCountValue = 0, oZero = 1, oCarry = 0, oLoadAck = 0; held while low.
- Per rising edge, first true condition wins:
  - iSet = 1 → count = 2^CountWidth−1; oCarry = 0; oLoadAck = 0.
  - iLoad = 1 → count = iPreldVal; oLoadAck = 1; oCarry = 0.
  - iEnable = 1, iUp = 1 → count+1 mod 2^CountWidth; oCarry = 1 iff old count was max.
  - iEnable = 1, iUp = 0 → count−1 mod 2^CountWidth; oCarry = 1 iff old count was 0.
  - else hold; oCarry = 0; oLoadAck = 0.
- Arithmetic unsigned, CountWidth bits; carry-out never widens the count.
- oZero computed from the next count value and registered alongside it, so it always matches oCountValue in the same cycle.
- Simultaneous controls: iSet+iLoad → set, no ack; iLoad+iEnable → load, no count, no carry; iSet+iEnable → set.
- iUp ignored when iEnable = 0 or a higher-priority control is active.

## Timing
- Latency: one clock from control/data inputs to oCountValue, oZero, oCarry, oLoadAck.
- oCarry and oLoadAck high for exactly one cycle per event; back-to-back events give back-to-back pulses (no gap required).
- No combinational path from inputs to outputs.
- Reset assertion mid-count clears outputs immediately (asynchronously); first update after deassertion occurs on the next rising edge, with controls applied normally.

## Configuration
- COUNT_SAT_EN defined: counting saturates. Up at max holds max; down at 0 holds 0; oCarry pulses on each enabled cycle that attempts to pass a bound (held value, not wrapped). Set/load unaffected.
- COUNT_SAT_EN undefined: modulo wrap as in Operation; oCarry pulses on wrap.

## Structure
- Shared package counter_pkg: default CountWidth, count-max constant derived from width, direction constants CNT_UP = 1 and CNT_DOWN = 0.
- One sub-module, count_next_sel: combinational next-value/flag selection (priority, increment/decrement, wrap/saturate, carry, ack); the top holds only the registers and the async reset.

## Test plan
- Reset: hold _iReset = 0 with iSet = 1, iEnable = 1 → oCountValue = 0x00, oZero = 1, oCarry = 0, oLoadAck = 0 throughout; release → counting starts at the next edge.
- Load then count up: iLoad with iPreldVal = 0xFD, then iEnable = 1, iUp = 1 for 3 cycles → 0xFD (oLoadAck pulse), 0xFE, 0xFF, 0x00 with oCarry = 1 and oZero = 1 on that cycle (wrap build); saturate build → 0xFF held, oCarry = 1.
- Count down through zero: load 0x01, down 2 cycles → 0x00 (oZero = 1), then 0xFF with oCarry = 1 (wrap build) or 0x00 held with oCarry = 1 (saturate build).
- Priority: iSet = 1, iLoad = 1, iPreldVal = 0x55, iEnable = 1 same cycle → 0xFF, oLoadAck = 0; next cycle iLoad = 1, iEnable = 1 → 0x55, oLoadAck = 1, oCarry = 0.
- Hold: iEnable = 0 for 5 cycles at 0x42 with iUp toggling → oCountValue stays 0x42, no pulses.
- Async reset mid-count: assert _iReset = 0 between edges while counting at 0x80 → outputs clear before the next edge.
